// File: rtl/fnd_scan_engine.sv
// fnd_scan_engine: sequential double-dabble BCD converter behind a valid/ready
// handshake, feeding an atomically committed buffer scanned onto a multiplexed FND.
module fnd_scan_engine #(
  parameter int NUM_DIGITS = 4,
  parameter int DATA_WIDTH = 14,
  parameter int CLK_HZ     = 100_000_000,
  parameter int SCAN_HZ    = 1000,
  parameter int BLINK_DIV  = 500
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    i_valid,
  input  logic [DATA_WIDTH-1:0]   i_bin,
  input  logic [NUM_DIGITS-1:0]   i_dot_mask,
  input  logic [NUM_DIGITS-1:0]   i_blink_mask,
  input  logic                    i_lz_blank,
  output logic                    o_ready,
  output logic [NUM_DIGITS-1:0]   o_digit,
  output logic [7:0]              o_seg,
  output logic [4*NUM_DIGITS-1:0] o_bcd
);

  function automatic logic [63:0] pow10(input int n);
    logic [63:0] p;
    p = 64'd1;
    for (int i = 0; i < n; i++) begin
      p = p * 64'd10;
    end
    return p;
  endfunction

  localparam int TICK_DIV = CLK_HZ / SCAN_HZ;
  localparam int TICK_W   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int BLINK_W  = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam int IDX_W    = $clog2(NUM_DIGITS);
  localparam int CNT_W    = $clog2(DATA_WIDTH + 1);
  localparam int BCD_W    = 4 * NUM_DIGITS;
  localparam logic [63:0] MAX_VAL = pow10(NUM_DIGITS) - 64'd1;

  // Add 3 to every nibble >= 5 ahead of the shift.
  function automatic logic [BCD_W-1:0] dd_adjust(input logic [BCD_W-1:0] s);
    logic [BCD_W-1:0] r;
    r = s;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (s[4*k +: 4] >= 4'd5) begin
        r[4*k +: 4] = s[4*k +: 4] + 4'd3;
      end else begin
        r[4*k +: 4] = s[4*k +: 4];
      end
    end
    return r;
  endfunction

  function automatic logic [6:0] seg7(input logic [3:0] nib);
    logic [6:0] s;
    case (nib)
      4'd0:    s = 7'h40;
      4'd1:    s = 7'h79;
      4'd2:    s = 7'h24;
      4'd3:    s = 7'h30;
      4'd4:    s = 7'h19;
      4'd5:    s = 7'h12;
      4'd6:    s = 7'h02;
      4'd7:    s = 7'h78;
      4'd8:    s = 7'h00;
      4'd9:    s = 7'h10;
      4'hF:    s = 7'h3F;
      default: s = 7'h7F;
    endcase
    return s;
  endfunction

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHIFT  = 2'd1,
    ST_COMMIT = 2'd2
  } state_t;

  state_t                r_state;
  logic [CNT_W-1:0]      r_cnt;
  logic [DATA_WIDTH-1:0] r_bin;
  logic [BCD_W-1:0]      r_scratch;
  logic                  r_ovf;
  logic [NUM_DIGITS-1:0] r_cap_dot;
  logic [NUM_DIGITS-1:0] r_cap_blink;
  logic                  r_cap_lz;
  logic [BCD_W-1:0]      r_buf;
  logic [NUM_DIGITS-1:0] r_dot;
  logic [NUM_DIGITS-1:0] r_blink;
  logic                  r_lz;
  logic                  r_ready;

  logic [TICK_W-1:0]     r_tick_cnt;
  logic [IDX_W-1:0]      r_idx;
  logic [BLINK_W-1:0]    r_blink_cnt;
  logic                  r_blink_off;
  logic [NUM_DIGITS-1:0] r_digit;
  logic [7:0]            r_seg;

  logic [BCD_W-1:0]      w_adj;
  logic                  w_tick;
  logic [3:0]            w_nib;
  logic [NUM_DIGITS-1:0] w_zero_from;
  logic [NUM_DIGITS-1:0] w_digit_nxt;
  logic [7:0]            w_seg_nxt;

  assign w_adj  = dd_adjust(r_scratch);
  assign w_tick = (r_tick_cnt == TICK_W'(TICK_DIV - 1));
  assign w_nib  = r_buf[{r_idx, 2'b00} +: 4];

  // Converter FSM: capture, DATA_WIDTH shift steps, one-cycle atomic commit.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_cnt       <= '0;
      r_bin       <= '0;
      r_scratch   <= '0;
      r_ovf       <= 1'b0;
      r_cap_dot   <= '0;
      r_cap_blink <= '0;
      r_cap_lz    <= 1'b0;
      r_buf       <= '0;
      r_dot       <= '0;
      r_blink     <= '0;
      r_lz        <= 1'b0;
      r_ready     <= 1'b1;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (i_valid) begin
            r_bin       <= i_bin;
            r_cap_dot   <= i_dot_mask;
            r_cap_blink <= i_blink_mask;
            r_cap_lz    <= i_lz_blank;
            r_ovf       <= (64'(i_bin) > MAX_VAL);
            r_scratch   <= '0;
            r_cnt       <= CNT_W'(DATA_WIDTH);
            r_ready     <= 1'b0;
            r_state     <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          r_scratch <= {w_adj[BCD_W-2:0], r_bin[DATA_WIDTH-1]};
          r_bin     <= {r_bin[DATA_WIDTH-2:0], 1'b0};
          r_cnt     <= r_cnt - CNT_W'(1);
          if (r_cnt == CNT_W'(1)) begin
            r_state <= ST_COMMIT;
          end
        end
        ST_COMMIT: begin
          // Overflowed values show dashes on every digit.
          r_buf   <= r_ovf ? {BCD_W{1'b1}} : r_scratch;
          r_dot   <= r_cap_dot;
          r_blink <= r_cap_blink;
          r_lz    <= r_cap_lz;
          r_ready <= 1'b1;
          r_state <= ST_IDLE;
        end
        default: begin
          r_ready <= 1'b1;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  // Digit k is a leading zero when nibbles k..NUM_DIGITS-1 are all zero.
  always_comb begin : zero_scan
    logic w_acc;
    w_acc       = 1'b1;
    w_zero_from = '0;
    for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
      w_acc          = w_acc & (r_buf[4*k +: 4] == 4'd0);
      w_zero_from[k] = w_acc;
    end
  end

  // Segment pattern and anode for the digit shown at the next tick.
  always_comb begin
    w_digit_nxt = ~(NUM_DIGITS'(1) << r_idx);
    if (r_blink_off && r_blink[r_idx]) begin
      w_seg_nxt = 8'hFF;
    end else if (r_lz && (r_idx != '0) && w_zero_from[r_idx]) begin
      w_seg_nxt = {~r_dot[r_idx], 7'h7F};
    end else begin
      w_seg_nxt = {~r_dot[r_idx], seg7(w_nib)};
    end
  end

  // Scan timebase, digit rotation, blink phase and registered pin drive.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_tick_cnt  <= '0;
      r_idx       <= '0;
      r_blink_cnt <= '0;
      r_blink_off <= 1'b0;
      r_digit     <= '1;
      r_seg       <= 8'hFF;
    end else if (w_tick) begin
      r_tick_cnt <= '0;
      r_digit    <= w_digit_nxt;
      r_seg      <= w_seg_nxt;
      r_idx      <= (r_idx == IDX_W'(NUM_DIGITS - 1)) ? '0 : r_idx + IDX_W'(1);
      if (r_blink_cnt == BLINK_W'(BLINK_DIV - 1)) begin
        r_blink_cnt <= '0;
        r_blink_off <= ~r_blink_off;
      end else begin
        r_blink_cnt <= r_blink_cnt + BLINK_W'(1);
      end
    end else begin
      r_tick_cnt <= r_tick_cnt + TICK_W'(1);
    end
  end

  assign o_ready = r_ready;
  assign o_digit = r_digit;
  assign o_seg   = r_seg;
  assign o_bcd   = r_buf;

endmodule

// File: tb/tb_fnd_scan_engine.sv
// Scoreboard bench for fnd_scan_engine: 4-digit and 6-digit instances checked
// against an arithmetic model of BCD value, scan order, blink and suppression.
module tb_fnd_scan_engine;
  localparam int CLK_HZ = 1000, SCAN_HZ = 100, BLINK_DIV = 4, TICK = 10;
  localparam int ND_A = 4, DW_A = 14, ND_B = 6, DW_B = 20;

  logic clk = 1'b0;
  logic reset;
  logic a_valid, a_lz, a_ready;
  logic [DW_A-1:0] a_bin;
  logic [ND_A-1:0] a_dot, a_blk, a_digit;
  logic [7:0] a_seg;
  logic [4*ND_A-1:0] a_bcd;
  logic b_valid, b_lz, b_ready;
  logic [DW_B-1:0] b_bin;
  logic [ND_B-1:0] b_dot, b_blk, b_digit;
  logic [7:0] b_seg;
  logic [4*ND_B-1:0] b_bcd;

  always #5 clk = ~clk;

  fnd_scan_engine #(.NUM_DIGITS(ND_A), .DATA_WIDTH(DW_A), .CLK_HZ(CLK_HZ),
                    .SCAN_HZ(SCAN_HZ), .BLINK_DIV(BLINK_DIV)) u_a (
    .clk(clk), .reset(reset), .i_valid(a_valid), .i_bin(a_bin),
    .i_dot_mask(a_dot), .i_blink_mask(a_blk), .i_lz_blank(a_lz),
    .o_ready(a_ready), .o_digit(a_digit), .o_seg(a_seg), .o_bcd(a_bcd));

  fnd_scan_engine #(.NUM_DIGITS(ND_B), .DATA_WIDTH(DW_B), .CLK_HZ(CLK_HZ),
                    .SCAN_HZ(SCAN_HZ), .BLINK_DIV(BLINK_DIV)) u_b (
    .clk(clk), .reset(reset), .i_valid(b_valid), .i_bin(b_bin),
    .i_dot_mask(b_dot), .i_blink_mask(b_blk), .i_lz_blank(b_lz),
    .o_ready(b_ready), .o_digit(b_digit), .o_seg(b_seg), .o_bcd(b_bcd));

  int cyc;
  always @(posedge clk or posedge reset) begin
    if (reset) cyc <= 0;
    else cyc <= cyc + 1;
  end

  int checks = 0, errors = 0;
  bit done = 1'b0;
  logic [31:0] scb_a[$], scb_b[$];
  bit prev_rdy[2];
  int unsigned m_oval[2], m_nval[2];
  int m_odot[2], m_ndot[2], m_oblk[2], m_nblk[2], m_commit[2];
  bit m_olz[2], m_nlz[2];

  function automatic int unsigned p10(input int n);
    int unsigned p = 1;
    for (int i = 0; i < n; i++) p = p * 10;
    return p;
  endfunction

  function automatic logic [31:0] exp_bcd(input int unsigned val, input int nd);
    logic [31:0] r = 32'd0;
    if (val > p10(nd) - 1) return (32'd1 << (4 * nd)) - 32'd1;
    for (int k = 0; k < nd; k++) r = r | (32'((val / p10(k)) % 10) << (4 * k));
    return r;
  endfunction

  function automatic logic [7:0] exp_seg(input int unsigned val, input int nd, input int k,
                                         input int dot, input int blk, input bit lz, input bit off);
    logic [7:0] tab [10];
    logic [7:0] e;
    logic [6:0] low;
    bit dp;
    tab = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};
    dp = ((dot >> k) & 1) != 0;
    if ((((blk >> k) & 1) != 0) && off) return 8'hFF;
    if (val > p10(nd) - 1) low = 7'h3F;
    else if (lz && k > 0 && val < p10(k)) low = 7'h7F;
    else begin
      e = tab[(val / p10(k)) % 10];
      low = e[6:0];
    end
    return {~dp, low};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cyc %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic rdy_of(input int d);
    return (d == 0) ? a_ready : b_ready;
  endfunction

  task automatic drive(input int d, input bit v, input int unsigned val,
                       input int dot, input int blk, input bit lz);
    if (d == 0) begin
      a_valid = v; a_bin = DW_A'(val); a_dot = ND_A'(dot); a_blk = ND_A'(blk); a_lz = lz;
    end else begin
      b_valid = v; b_bin = DW_B'(val); b_dot = ND_B'(dot); b_blk = ND_B'(blk); b_lz = lz;
    end
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_oval[d] = 0; m_nval[d] = 0; m_odot[d] = 0; m_ndot[d] = 0;
      m_oblk[d] = 0; m_nblk[d] = 0; m_olz[d] = 0; m_nlz[d] = 0; m_commit[d] = 0;
    end
  endtask

  task automatic settle(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  // Issue one load; optionally hold a junk request high while the converter is busy.
  task automatic send(input int d, input int unsigned val, input int dot, input int blk,
                      input bit lz, input bit hold);
    int w = 0, low = 0, acc, dw;
    dw = (d == 0) ? DW_A : DW_B;
    while (!rdy_of(d) && w < 300) begin settle(1); w++; end
    if (w >= 300) begin
      checks++; errors++;
      $display("FAIL ready_timeout: got busy expected ready (dut %0d)", d);
      return;
    end
    drive(d, 1'b1, val, dot, blk, lz);
    settle(1);
    acc = cyc;
    drive(d, 1'b0, 0, 0, 0, 1'b0);
    if (d == 0) scb_a.push_back(exp_bcd(val, ND_A));
    else scb_b.push_back(exp_bcd(val, ND_B));
    m_oval[d] = m_nval[d]; m_odot[d] = m_ndot[d]; m_oblk[d] = m_nblk[d]; m_olz[d] = m_nlz[d];
    m_nval[d] = val; m_ndot[d] = dot; m_nblk[d] = blk; m_nlz[d] = lz;
    m_commit[d] = acc + dw + 1;
    while (!rdy_of(d) && low < 300) begin
      if (hold && low < 10) drive(d, 1'b1, 99, 0, 0, 1'b0);
      else drive(d, 1'b0, 0, 0, 0, 1'b0);
      settle(1);
      low++;
    end
    drive(d, 1'b0, 0, 0, 0, 1'b0);
    chk("busy_cycles", 32'(low), 32'(dw + 1));
  endtask

  // Per-negedge check of one instance against the model.
  task automatic mon_one(input int d);
    int nd, n, t, k;
    bit off, use_new;
    logic rdy;
    logic [7:0] dig, seg;
    logic [31:0] bcd, all1, e;
    nd = (d == 0) ? ND_A : ND_B;
    if (d == 0) begin rdy = a_ready; dig = 8'(a_digit); seg = a_seg; bcd = 32'(a_bcd); end
    else begin rdy = b_ready; dig = 8'(b_digit); seg = b_seg; bcd = 32'(b_bcd); end
    all1 = (32'd1 << nd) - 32'd1;
    if (reset) begin
      chk("rst_ready", 32'(rdy), 32'd1);
      chk("rst_digit", 32'(dig), all1);
      chk("rst_seg", 32'(seg), 32'hFF);
      chk("rst_bcd", bcd, 32'd0);
      prev_rdy[d] = 1'b1;
      return;
    end
    if (cyc < TICK) begin
      chk("pre_tick_digit", 32'(dig), all1);
      chk("pre_tick_seg", 32'(seg), 32'hFF);
    end else begin
      n = cyc / TICK;
      t = n * TICK;
      k = (n - 1) % nd;
      off = (((n - 1) / BLINK_DIV) % 2) != 0;
      use_new = t > m_commit[d];
      chk("scan_digit", 32'(dig), all1 & ~(32'd1 << k));
      if (use_new) e = 32'(exp_seg(m_nval[d], nd, k, m_ndot[d], m_nblk[d], m_nlz[d], off));
      else e = 32'(exp_seg(m_oval[d], nd, k, m_odot[d], m_oblk[d], m_olz[d], off));
      chk("scan_seg", 32'(seg), e);
    end
    if (!prev_rdy[d] && rdy) begin
      if ((d == 0 && scb_a.size() == 0) || (d == 1 && scb_b.size() == 0)) begin
        checks++; errors++;
        $display("FAIL unexpected_commit: got bcd %h expected none (dut %0d)", bcd, d);
      end else begin
        e = (d == 0) ? scb_a.pop_front() : scb_b.pop_front();
        chk("bcd", bcd, e);
      end
    end
    prev_rdy[d] = rdy;
  endtask

  initial begin
    reset = 1'b1;
    drive(0, 1'b0, 0, 0, 0, 1'b0);
    drive(1, 1'b0, 0, 0, 0, 1'b0);
    model_reset();
    prev_rdy[0] = 1'b1; prev_rdy[1] = 1'b1;
    fork
      begin
        while (!done) begin
          @(negedge clk);
          mon_one(0);
          mon_one(1);
        end
      end
      begin
        settle(3);
        reset = 1'b0;
        settle(30);
        send(0, 1234, 0, 0, 1'b0, 1'b0);   settle(100);
        send(0, 7, 0, 0, 1'b1, 1'b0);      settle(100);
        send(0, 0, 0, 0, 1'b1, 1'b0);      settle(100);
        send(0, 7, 4, 0, 1'b1, 1'b0);      settle(100);
        send(0, 10000, 0, 0, 1'b0, 1'b0);  settle(100);
        send(0, 9999, 0, 0, 1'b0, 1'b0);   settle(100);
        send(0, 5, 1, 1, 1'b0, 1'b0);      settle(200);
        send(0, 42, 0, 0, 1'b0, 1'b1);     settle(100);
        send(1, 987654, 0, 0, 1'b0, 1'b0); settle(150);
        // Abort a conversion five cycles after acceptance.
        drive(0, 1'b1, 321, 3, 0, 1'b0);
        settle(1);
        drive(0, 1'b0, 0, 0, 0, 1'b0);
        settle(5);
        reset = 1'b1;
        #1;
        chk("abort_ready", 32'(a_ready), 32'd1);
        chk("abort_bcd", 32'(a_bcd), 32'd0);
        chk("abort_seg", 32'(a_seg), 32'hFF);
        scb_a.delete(); scb_b.delete();
        model_reset();
        settle(2);
        reset = 1'b0;
        settle(50);
        for (int i = 0; i < 6; i++) begin
          send(0, $urandom_range(0, 16383), $urandom_range(0, 15), $urandom_range(0, 15),
               1'($urandom_range(0, 1)), 1'b0);
          settle(120);
          send(1, $urandom_range(0, 1048575), $urandom_range(0, 63), $urandom_range(0, 63),
               1'($urandom_range(0, 1)), 1'b0);
          settle(130);
        end
        done = 1'b1;
      end
    join
    chk("scb_a_leftover", 32'(scb_a.size()), 32'd0);
    chk("scb_b_leftover", 32'(scb_b.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
